// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART receiver and the command parser.
package uart_cmd_pkg;

    // Receiver state encodings, shared with the UART receiver
    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_WAIT_START = 3'd1,
        RX_START      = 3'd2,
        RX_DATA       = 3'd3,
        RX_STOP       = 3'd4
    } rx_state_t;

    // Default start-of-frame marker
    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    // Command parser states
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_OP      = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } parse_state_t;

    // Running XOR checksum step
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Derives one strobe per received UART byte from the receiver's DATA->STOP transition.
module uart_byte_strobe
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic [2:0] rx_state,
    output logic       strobe,
    output logic [7:0] rx_byte
);

    logic [2:0] prev_state_r;

    // Remember last receiver state so the DATA->STOP edge can be detected
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state_r <= RX_IDLE;
        end else begin
            prev_state_r <= rx_state;
        end
    end

    // The shift register is final on the first STOP cycle, so the byte is taken there
    assign strobe  = (prev_state_r == RX_DATA) && (rx_state == RX_STOP);
    assign rx_byte = rx_data;

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames [SOF][OP][LEN][PAYLOAD x LEN][CHK] from UART bytes and holds each good frame
// for the executor behind a valid/ready handshake.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 270000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic [2:0]                   rx_state,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [7:0]                   cmd_op,
    output logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [$clog2(MAX_LEN)-1:0]   pay_addr,
    output logic [7:0]                   pay_data,
    output logic                         err_chk,
    output logic                         err_len,
    output logic                         err_timeout,
    output logic                         err_overrun
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    logic          strobe_s;
    logic [7:0]    byte_s;
    parse_state_t  state_r;
    logic [LW-1:0] idx_r;
    logic [7:0]    chk_r;
    logic [TW-1:0] to_cnt_r;
    logic [7:0]    pay_buf_r [MAX_LEN];

    uart_byte_strobe u_strobe (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_state (rx_state),
        .strobe   (strobe_s),
        .rx_byte  (byte_s)
    );

    // Frame FSM, inter-byte timeout, checksum and registered status/error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HUNT;
            cmd_valid   <= 1'b0;
            cmd_op      <= 8'h00;
            cmd_len     <= '0;
            idx_r       <= '0;
            chk_r       <= 8'h00;
            to_cnt_r    <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    to_cnt_r <= '0;
                    if (strobe_s && (byte_s == SOF_BYTE)) begin
                        chk_r   <= 8'h00;
                        state_r <= ST_OP;
                    end
                end
                ST_OP, ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                    // A byte arriving on the timeout cycle is processed, not timed out
                    if (strobe_s) begin
                        to_cnt_r <= '0;
                        case (state_r)
                            ST_OP: begin
                                cmd_op  <= byte_s;
                                chk_r   <= chk_update(chk_r, byte_s);
                                state_r <= ST_LEN;
                            end
                            ST_LEN: begin
                                chk_r <= chk_update(chk_r, byte_s);
                                if (byte_s > MAX_LEN_B) begin
                                    err_len <= 1'b1;
                                    state_r <= ST_HUNT;
                                end else begin
                                    cmd_len <= byte_s[LW-1:0];
                                    idx_r   <= '0;
                                    state_r <= (byte_s == 8'h00) ? ST_CHECK : ST_PAYLOAD;
                                end
                            end
                            ST_PAYLOAD: begin
                                chk_r <= chk_update(chk_r, byte_s);
                                idx_r <= idx_r + LW'(1);
                                if ((idx_r + LW'(1)) == cmd_len) begin
                                    state_r <= ST_CHECK;
                                end
                            end
                            ST_CHECK: begin
                                if (byte_s == chk_r) begin
                                    cmd_valid <= 1'b1;
                                    state_r   <= ST_HOLD;
                                end else begin
                                    err_chk <= 1'b1;
                                    state_r <= ST_HUNT;
                                end
                            end
                            default: state_r <= ST_HUNT;
                        endcase
                    end else if (to_cnt_r == TO_LAST) begin
                        err_timeout <= 1'b1;
                        to_cnt_r    <= '0;
                        state_r     <= ST_HUNT;
                    end else begin
                        to_cnt_r <= to_cnt_r + TW'(1);
                    end
                end
                ST_HOLD: begin
                    to_cnt_r <= '0;
                    if (cmd_ready) begin
                        // Handshake completes; a byte in the same cycle is a fresh hunt byte
                        cmd_valid <= 1'b0;
                        if (strobe_s && (byte_s == SOF_BYTE)) begin
                            chk_r   <= 8'h00;
                            state_r <= ST_OP;
                        end else begin
                            state_r <= ST_HUNT;
                        end
                    end else if (strobe_s) begin
                        err_overrun <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_HUNT;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload buffer write port; contents are intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && strobe_s && (state_r == ST_PAYLOAD)) begin
            pay_buf_r[idx_r[AW-1:0]] <= byte_s;
        end
    end

    // Asynchronous payload read, zero beyond the held frame's length
    always_comb begin
        pay_data = 8'h00;
        if (LW'(pay_addr) < cmd_len) begin
            pay_data = pay_buf_r[pay_addr];
        end else begin
            pay_data = 8'h00;
        end
    end

endmodule
